// File: rtl/rsa_sequencer.sv
// Job controller for the rsa modular-exponentiation core: programs operands over the
// register bus, starts the core, waits (with timeout) for the result and hands it back.
module rsa_sequencer #(
    parameter logic [7:0]  ADDR_BASE      = 8'h08,
    parameter logic [7:0]  ADDR_EXP       = 8'h0C,
    parameter logic [7:0]  ADDR_MOD       = 8'h10,
    parameter logic [7:0]  ADDR_CTRL      = 8'h14,
    parameter logic [7:0]  ADDR_RESULT    = 8'h18,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        pclk,
    input  logic        nreset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_base,
    input  logic [31:0] job_exp,
    input  logic [31:0] job_mod,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        busy,
    output logic        fabint,
    output logic        rsa_write_en,
    output logic        rsa_read_en,
    output logic        rsa_enable,
    output logic [7:0]  rsa_addr,
    output logic [31:0] rsa_wdata,
    input  logic [31:0] rsa_rdata,
    input  logic        rsa_result_valid
);

    localparam int unsigned CNT_W = 24;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_BASE,
        S_WR_EXP,
        S_WR_MOD,
        S_WR_CTRL,
        S_WAIT,
        S_RD_REQ,
        S_RD_CAP,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [31:0]      base_q, exp_q, mod_q;
    logic [31:0]      base_n, exp_n, mod_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             err_n;
    logic [31:0]      data_n;
    logic             wr_n, rd_n;
    logic [7:0]       addr_n;
    logic [31:0]      wdata_n;

    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, next datapath values, and bus outputs decoded from the next state
    always_comb begin
        state_next = state;
        base_n     = base_q;
        exp_n      = exp_q;
        mod_n      = mod_q;
        cnt_n      = cnt_q;
        err_n      = res_err;
        data_n     = res_data;
        wr_n       = 1'b0;
        rd_n       = 1'b0;
        addr_n     = 8'h00;
        wdata_n    = 32'h0;

        case (state)
            S_IDLE: begin
                if (job_valid && job_ready) begin
                    base_n     = job_base;
                    exp_n      = job_exp;
                    mod_n      = job_mod;
                    data_n     = 32'h0;
                    state_next = S_WR_BASE;
                end
            end
            S_WR_BASE: state_next = S_WR_EXP;
            S_WR_EXP:  state_next = S_WR_MOD;
            S_WR_MOD:  state_next = S_WR_CTRL;
            S_WR_CTRL: begin
                cnt_n      = CNT_W'(TIMEOUT_CYCLES);
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the last counted cycle still wins over expiry
                if (rsa_result_valid) begin
                    state_next = S_RD_REQ;
                end else if (cnt_q == '0) begin
                    err_n      = 1'b1;
                    state_next = S_DONE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_RD_REQ: state_next = S_RD_CAP;
            S_RD_CAP: begin
                data_n     = rsa_rdata;
                state_next = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    err_n      = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        case (state_next)
            S_WR_BASE: begin
                wr_n    = 1'b1;
                addr_n  = ADDR_BASE;
                wdata_n = base_n;
            end
            S_WR_EXP: begin
                wr_n    = 1'b1;
                addr_n  = ADDR_EXP;
                wdata_n = exp_n;
            end
            S_WR_MOD: begin
                wr_n    = 1'b1;
                addr_n  = ADDR_MOD;
                wdata_n = mod_n;
            end
            S_WR_CTRL: begin
                wr_n    = 1'b1;
                addr_n  = ADDR_CTRL;
                wdata_n = 32'h1;
            end
            S_RD_REQ: begin
                rd_n   = 1'b1;
                addr_n = ADDR_RESULT;
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            base_q       <= 32'h0;
            exp_q        <= 32'h0;
            mod_q        <= 32'h0;
            cnt_q        <= '0;
            res_err      <= 1'b0;
            res_data     <= 32'h0;
            job_ready    <= 1'b1;
            busy         <= 1'b0;
            res_valid    <= 1'b0;
            fabint       <= 1'b0;
            rsa_write_en <= 1'b0;
            rsa_read_en  <= 1'b0;
            rsa_enable   <= 1'b0;
            rsa_addr     <= 8'h00;
            rsa_wdata    <= 32'h0;
        end else begin
            base_q       <= base_n;
            exp_q        <= exp_n;
            mod_q        <= mod_n;
            cnt_q        <= cnt_n;
            res_err      <= err_n;
            res_data     <= data_n;
            job_ready    <= (state_next == S_IDLE);
            busy         <= (state_next != S_IDLE);
            res_valid    <= (state_next == S_DONE);
            fabint       <= (state_next == S_DONE);
            rsa_write_en <= wr_n;
            rsa_read_en  <= rd_n;
            rsa_enable   <= wr_n | rd_n;
            rsa_addr     <= addr_n;
            rsa_wdata    <= wdata_n;
        end
    end

endmodule

// File: tb/tb_rsa_sequencer.sv
// Randomized self-checking bench for rsa_sequencer with an rsa core model and a
// job-timeline reference model.
module tb_rsa_sequencer;

    localparam int TO = 20;

    logic        pclk = 1'b0;
    logic        nreset;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_base, job_exp, job_mod;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
    logic        busy;
    logic        fabint;
    logic        rsa_write_en, rsa_read_en, rsa_enable;
    logic [7:0]  rsa_addr;
    logic [31:0] rsa_wdata;
    logic [31:0] rsa_rdata;
    logic        rsa_result_valid;

    rsa_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk             (pclk),
        .nreset           (nreset),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_base         (job_base),
        .job_exp          (job_exp),
        .job_mod          (job_mod),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_err          (res_err),
        .busy             (busy),
        .fabint           (fabint),
        .rsa_write_en     (rsa_write_en),
        .rsa_read_en      (rsa_read_en),
        .rsa_enable       (rsa_enable),
        .rsa_addr         (rsa_addr),
        .rsa_wdata        (rsa_wdata),
        .rsa_rdata        (rsa_rdata),
        .rsa_result_valid (rsa_result_valid)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // stimulus-owned knobs
    int          core_delay = 1000;
    int          rr_mode    = 0;
    int          lit_lat    = -1;
    int          lit_err    = -1;
    int          lit_res_en = 0;
    logic [31:0] lit_res    = 32'h0;

    // reference model state (one job timeline measured from the acceptance edge)
    bit          m_active = 1'b0;
    int          m_t = 0, m_done_t = 0, m_acc_cyc = 0;
    bit          m_ok = 1'b0;
    logic [31:0] m_res = 32'h0, m_base = 32'h0, m_exp = 32'h0, m_mod = 32'h0;

    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                           input logic [31:0] m);
        logic [63:0] r, x, mm;
        if (m == 32'h0) return 32'h0;
        mm = 64'(m);
        r  = 64'(1) % mm;
        x  = 64'(b) % mm;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: job accepted when idle, fixed 4 writes, core wait, read, done
    initial begin
        forever begin
            @(posedge pclk or negedge nreset);
            if (!nreset) begin
                m_active = 1'b0;
                m_t      = 0;
            end else begin
                cyc++;
                if (!m_active) begin
                    if (job_valid) begin
                        m_active  = 1'b1;
                        m_t       = 1;
                        m_base    = job_base;
                        m_exp     = job_exp;
                        m_mod     = job_mod;
                        m_res     = modexp(job_base, job_exp, job_mod);
                        m_ok      = (core_delay <= TO);
                        m_done_t  = m_ok ? 8 + core_delay : TO + 6;
                        m_acc_cyc = cyc;
                    end
                end else if (m_t >= m_done_t) begin
                    if (res_ready) m_active = 1'b0;
                end else begin
                    m_t++;
                end
            end
        end
    end

    // Compare process: all outputs every cycle
    initial begin
        logic        e_wr, e_rd, e_rv, e_err, prev_rv;
        logic [7:0]  e_addr;
        logic [31:0] e_wd;
        bit          pinned;
        prev_rv = 1'b0;
        pinned  = 1'b0;
        forever begin
            @(negedge pclk);
            if (!pinned) begin
                chk("model_modexp", modexp(32'd4, 32'd13, 32'd497), 32'd445);
                pinned = 1'b1;
            end
            e_wr = 1'b0; e_rd = 1'b0; e_addr = 8'h00; e_wd = 32'h0;
            if (m_active) begin
                case (m_t)
                    1: begin e_wr = 1'b1; e_addr = 8'h08; e_wd = m_base; end
                    2: begin e_wr = 1'b1; e_addr = 8'h0C; e_wd = m_exp;  end
                    3: begin e_wr = 1'b1; e_addr = 8'h10; e_wd = m_mod;  end
                    4: begin e_wr = 1'b1; e_addr = 8'h14; e_wd = 32'h1;  end
                    default: ;
                endcase
                if (m_ok && m_t == m_done_t - 2) begin
                    e_rd = 1'b1; e_addr = 8'h18;
                end
            end
            e_rv  = m_active && (m_t >= m_done_t);
            e_err = e_rv && !m_ok;
            chk("job_ready",    32'(job_ready),    32'(!m_active));
            chk("busy",         32'(busy),         32'(m_active));
            chk("res_valid",    32'(res_valid),    32'(e_rv));
            chk("fabint",       32'(fabint),       32'(e_rv));
            chk("res_err",      32'(res_err),      32'(e_err));
            chk("rsa_write_en", 32'(rsa_write_en), 32'(e_wr));
            chk("rsa_read_en",  32'(rsa_read_en),  32'(e_rd));
            chk("rsa_enable",   32'(rsa_enable),   32'(e_wr | e_rd));
            chk("rsa_addr",     32'(rsa_addr),     32'(e_addr));
            chk("rsa_wdata",    rsa_wdata,         e_wd);
            if (e_rv) chk("res_data", res_data, m_ok ? m_res : 32'h0);
            if (!nreset) chk("res_data_reset", res_data, 32'h0);
            if (res_valid && !prev_rv && nreset) begin
                if (lit_lat >= 0) chk("latency_lit", 32'(cyc - m_acc_cyc), 32'(lit_lat));
                if (lit_err >= 0) chk("res_err_lit", 32'(res_err), 32'(lit_err));
                if (lit_res_en != 0) chk("res_data_lit", res_data, lit_res);
            end
            prev_rv = res_valid;
        end
    end

    // rsa core model: captures bus writes, raises result_valid core_delay WAIT cycles after start
    initial begin
        logic [31:0] c_base, c_exp, c_mod;
        int          cnt, cd;
        bit          armed;
        c_base = 32'h0; c_exp = 32'h0; c_mod = 32'h0;
        cnt = 0; cd = 0; armed = 1'b0;
        rsa_result_valid = 1'b0;
        rsa_rdata        = 32'hDEAD_BEEF;
        forever begin
            @(negedge pclk);
            if (rsa_write_en && rsa_enable) begin
                case (rsa_addr)
                    8'h08: c_base = rsa_wdata;
                    8'h0C: c_exp  = rsa_wdata;
                    8'h10: c_mod  = rsa_wdata;
                    8'h14: begin
                        armed = 1'b1; cnt = 0; cd = core_delay;
                        rsa_result_valid = 1'b0;
                        rsa_rdata = $urandom;
                    end
                    default: ;
                endcase
            end else if (armed) begin
                rsa_result_valid = (cnt >= cd);
                if (cnt < 100000) cnt++;
            end
            if (rsa_read_en && rsa_enable && rsa_addr == 8'h18)
                rsa_rdata = modexp(c_base, c_exp, c_mod);
        end
    end

    // res_ready driver: 0 = always ready, 1 = random, 2 = low for the first 5 DONE cycles
    initial begin
        int hold;
        hold = 0;
        res_ready = 1'b0;
        forever begin
            @(negedge pclk);
            if (res_valid) hold++; else hold = 0;
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = (hold > 5);
            endcase
        end
    end

    task automatic present(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                           input int d);
        job_base   = b;
        job_exp    = e;
        job_mod    = m;
        core_delay = d;
        job_valid  = 1'b1;
    endtask

    task automatic wait_accept();
        int k;
        k = 0;
        while (!job_ready) begin
            @(negedge pclk);
            k++;
            if (k > 300) begin
                $display("FAIL watchdog_accept: job_ready stuck low after %0d cycles", k);
                $fatal(1);
            end
        end
        @(negedge pclk);
        job_valid = 1'b0;
        job_base  = $urandom;
        job_exp   = $urandom;
        job_mod   = $urandom;
    endtask

    task automatic wait_done(input bit overlap);
        int k;
        k = 0;
        while (!res_valid) begin
            @(negedge pclk);
            k++;
            if (k > 300) begin
                $display("FAIL watchdog_result: res_valid stuck low after %0d cycles", k);
                $fatal(1);
            end
        end
        @(negedge pclk);
        if (!overlap) begin
            k = 0;
            while (res_valid) begin
                @(negedge pclk);
                k++;
                if (k > 300) begin
                    $display("FAIL watchdog_handshake: res_valid stuck high");
                    $fatal(1);
                end
            end
        end
    endtask

    task automatic set_lit(input int lat, input int err, input int en, input logic [31:0] r);
        lit_lat    = lat;
        lit_err    = err;
        lit_res_en = en;
        lit_res    = r;
    endtask

    initial begin
        int k;
        job_valid = 1'b0;
        job_base  = 32'h0;
        job_exp   = 32'h0;
        job_mod   = 32'h0;
        nreset    = 1'b1;
        #1 nreset = 1'b0;
        repeat (3) @(negedge pclk);
        nreset = 1'b1;
        repeat (3) @(negedge pclk);

        // directed job, immediate consume, then with res_ready held off
        rr_mode = 0;
        set_lit(17, 0, 1, 32'd445);
        present(32'd4, 32'd13, 32'd497, 10);
        wait_accept();
        wait_done(1'b0);
        rr_mode = 2;
        present(32'd4, 32'd13, 32'd497, 10);
        wait_accept();
        wait_done(1'b0);

        // core never answers: timeout
        rr_mode = 0;
        set_lit(TO + 5, 1, 1, 32'h0);
        present(32'h1234, 32'h55, 32'h9999, 1000);
        wait_accept();
        wait_done(1'b0);

        // result arrives on the very cycle the counter hits zero
        set_lit(TO + 7, 0, 1, 32'd24);
        present(32'd2, 32'd10, 32'd1000, TO);
        wait_accept();
        wait_done(1'b0);

        // one cycle later it is a timeout
        set_lit(TO + 5, 1, 1, 32'h0);
        present(32'd2, 32'd10, 32'd1000, TO + 1);
        wait_accept();
        wait_done(1'b0);

        // held-off second job during WAIT, reset mid-job, then that job completes
        set_lit(-1, -1, 0, 32'h0);
        present(32'd9, 32'd9, 32'd101, 1000);
        wait_accept();
        repeat (8) @(negedge pclk);
        set_lit(10, 0, 1, 32'd10);
        present(32'd7, 32'd5, 32'd33, 3);
        repeat (3) @(negedge pclk);
        @(posedge pclk);
        #2 nreset = 1'b0;
        repeat (2) @(negedge pclk);
        nreset = 1'b1;
        wait_accept();
        wait_done(1'b0);

        // randomized jobs with random consume and back-to-back presentation
        set_lit(-1, -1, 0, 32'h0);
        rr_mode = 1;
        for (int j = 0; j < 40; j++) begin
            logic [31:0] m;
            m = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 1000)) : ($urandom | 32'h1);
            present($urandom, $urandom, m, $urandom_range(0, TO + 3));
            wait_accept();
            wait_done(1'($urandom_range(0, 1)));
        end

        k = 0;
        while (busy && k < 300) begin
            @(negedge pclk);
            k++;
        end
        repeat (5) @(negedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/rsa_sequencer.md
Name: rsa_sequencer

Overview:
- Hardware job controller for the rsa modular-exponentiation core. It accepts one job (base, exponent, modulus) from a fabric requester and programs the core through its register-style bus port. It starts the core, waits for result_valid with a timeout, reads back the result and returns it over a valid/ready handshake.
- Sits beside the APB3 interface, so fabric logic can run RSA operations without the Cortex-M3 performing register writes. Raises fabint on completion.

Parameters:
- ADDR_BASE, 8'h08, rsa register address for base operand
- ADDR_EXP, 8'h0C, rsa register address for exponent
- ADDR_MOD, 8'h10, rsa register address for modulus
- ADDR_CTRL, 8'h14, rsa control register; writing 32'h1 starts the core
- ADDR_RESULT, 8'h18, rsa result register (read)
- TIMEOUT_CYCLES, 65535, max pclk cycles to wait for result_valid; must be ≥1 and < 2^24

Ports:
- pclk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- job_valid  in  1  requester presents a job
- job_ready  out  1  sequencer accepts a job this cycle
- job_base  in  32  base operand
- job_exp  in  32  exponent
- job_mod  in  32  modulus
- res_valid  out  1  result/status available
- res_ready  in  1  requester consumes result
- res_data  out  32  result value (0 on error)
- res_err  out  1  1 = timeout occurred
- busy  out  1  job in progress (not IDLE)
- fabint  out  1  level interrupt; set with res_valid, cleared when the result is consumed
- rsa_write_en  out  1  write strobe to rsa core
- rsa_read_en  out  1  read strobe to rsa core
- rsa_enable  out  1  rsa select, high with either strobe
- rsa_addr  out  8  rsa register address
- rsa_wdata  out  32  rsa write data
- rsa_rdata  in  32  rsa read data
- rsa_result_valid  in  1  rsa core result valid

Behaviour:
- Reset (nreset low, asynchronous): state IDLE.
  - All outputs 0, except job_ready = 1.
  - Operand registers, result register and timeout counter cleared.
- Deassertion of reset is synchronous to pclk: the design relies on an external reset synchronizer.
- All rsa_* outputs are registered. rsa_addr and rsa_wdata are 0 whenever no strobe is active.
- IDLE
  - job_ready = 1.
  - On job_valid & job_ready: latch the three operands, go to WR_BASE.
  - Operand inputs are ignored at all other times.
- WR_BASE, WR_EXP, WR_MOD: one cycle each.
  - rsa_write_en = rsa_enable = 1.
  - rsa_addr and rsa_wdata are taken from the matching parameter and latched operand.
- WR_CTRL: one cycle; write 32'h1 to ADDR_CTRL. Load the timeout counter with TIMEOUT_CYCLES. Go to WAIT.
- WAIT
  - No strobes. The counter decrements each cycle.
  - If rsa_result_valid = 1: go to RD_REQ. Valid takes priority over expiry in the same cycle.
  - Else if the counter = 0: set the error flag, go to DONE.
- RD_REQ: rsa_read_en = rsa_enable = 1, rsa_addr = ADDR_RESULT. Go to RD_CAP.
- RD_CAP: strobes low. Capture rsa_rdata into res_data. Go to DONE.
  - Read latency is fixed at one cycle: data is sampled on the edge after the strobe cycle.
- DONE
  - res_valid = 1 and fabint = 1. res_data is stable; res_err reflects the error flag.
  - On res_valid & res_ready: clear res_valid, fabint and the error flag, go to IDLE.
  - job_ready returns to 1 on the following cycle, so there is no same-cycle turnaround.
- Latency: job acceptance to res_valid is 7 + N cycles, where N is the number of WAIT cycles before rsa_result_valid is seen.
- Timeout: res_valid rises TIMEOUT_CYCLES+1 cycles after WR_CTRL, with res_err = 1 and res_data = 0.
- busy = 1 in every state except IDLE.
- job_valid while busy is held off (job_ready = 0). The requester must hold the job stable until it is accepted.
- rsa_result_valid outside WAIT is ignored. A stale high level from a prior job is acceptable because WR_CTRL restarts the core.
- Reset mid-job aborts immediately. No partial result is produced and fabint is dropped.

Test Plan:
- Reset then idle → job_ready = 1; res_valid, fabint, busy and all rsa_* outputs = 0.
- Job base=4, exp=13, mod=497; the bench core raises result_valid 10 cycles after start with result 445.
  - Writes seen in order: (08,4), (0C,13), (10,497), (14,1), one per cycle.
  - One read of 0x18.
  - res_data = 445, res_err = 0, fabint = 1; latency 7+10.
- Same job with res_ready held low for 5 cycles → res_valid, fabint and res_data stay stable until res_ready; job_ready is 0 until the cycle after the handshake.
- TIMEOUT_CYCLES = 20, core never responds → res_valid rises 21 cycles after the control write; res_err = 1, res_data = 0, no read strobe issued.
- result_valid asserted in the exact cycle the counter reaches 0 → result path taken, res_err = 0.
- Second job_valid during WAIT is not accepted. Asserting nreset during WAIT → all outputs at reset values in the same cycle; a new job then completes normally.
